// File: rtl/traffic_pkg.sv
// Shared phase encoding, lamp decode and default timing for the intersection controller.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package traffic_pkg;

    // Phase encoding; the numeric values are visible on o_state.
    typedef enum logic [2:0] {
        NS_GRN   = 3'd0,
        NS_YEL   = 3'd1,
        AR_TO_EW = 3'd2,
        EW_GRN   = 3'd3,
        EW_YEL   = 3'd4,
        AR_TO_NS = 3'd5
    } phase_e;

    // Default durations, all counted in ticks.
    localparam int DEF_CNT_W        = 5;
    localparam int DEF_NS_MIN_GREEN = 8;
    localparam int DEF_NS_MAX_GREEN = 31;
    localparam int DEF_EW_MIN_GREEN = 4;
    localparam int DEF_EW_MAX_GREEN = 15;
    localparam int DEF_YELLOW_T     = 3;
    localparam int DEF_ALLRED_T     = 1;

    typedef struct packed {
        logic ns_red;
        logic ns_yellow;
        logic ns_green;
        logic ew_red;
        logic ew_yellow;
        logic ew_green;
    } lamps_t;

    // One lamp per direction; unused encodings fall back to all-red.
    function automatic lamps_t lamp_decode(input phase_e ph);
        lamps_t l;
        l = '0;
        case (ph)
            NS_GRN:  begin l.ns_green  = 1'b1; l.ew_red    = 1'b1; end
            NS_YEL:  begin l.ns_yellow = 1'b1; l.ew_red    = 1'b1; end
            EW_GRN:  begin l.ns_red    = 1'b1; l.ew_green  = 1'b1; end
            EW_YEL:  begin l.ns_red    = 1'b1; l.ew_yellow = 1'b1; end
            default: begin l.ns_red    = 1'b1; l.ew_red    = 1'b1; end
        endcase
        return l;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Saturating tick counter measuring time spent in the current phase.
// Latency: count visible one cycle after the tick or clear.
// Backpressure: none; clear has priority over tick.
module phase_timer #(
    parameter int CNT_W = 5
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_tick,
    output logic [CNT_W-1:0] o_cnt
);

    localparam logic [CNT_W-1:0] MAX_CNT = '1;

    logic [CNT_W-1:0] r_cnt;

    // Clear on phase change, otherwise count ticks and hold at all-ones.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_tick && (r_cnt != MAX_CNT)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/traffic_phase_sequencer.sv
// Actuated two-way (NS/EW) signal controller with call latches and emergency preemption.
// Latency: phase and lamps update on the clock edge of the deciding tick; lamps are registered.
// Backpressure: none; inputs are levels/strobes sampled every cycle.
module traffic_phase_sequencer
    import traffic_pkg::*;
#(
    parameter int CNT_W        = DEF_CNT_W,
    parameter int NS_MIN_GREEN = DEF_NS_MIN_GREEN,
    parameter int NS_MAX_GREEN = DEF_NS_MAX_GREEN,
    parameter int EW_MIN_GREEN = DEF_EW_MIN_GREEN,
    parameter int EW_MAX_GREEN = DEF_EW_MAX_GREEN,
    parameter int YELLOW_T     = DEF_YELLOW_T,
    parameter int ALLRED_T     = DEF_ALLRED_T
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_tick,
    input  logic             i_ns_detect,
    input  logic             i_ew_detect,
    input  logic             i_preempt,
    input  logic             i_preempt_dir,
    output logic             o_ns_red,
    output logic             o_ns_yellow,
    output logic             o_ns_green,
    output logic             o_ew_red,
    output logic             o_ew_yellow,
    output logic             o_ew_green,
    output logic [2:0]       o_state,
    output logic [CNT_W-1:0] o_timer
);

    // "Duration T reached" means the timer shows T-1 on the deciding tick.
    localparam logic [CNT_W-1:0] NS_MIN_M1 = CNT_W'(NS_MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] NS_MAX_M1 = CNT_W'(NS_MAX_GREEN - 1);
    localparam logic [CNT_W-1:0] EW_MIN_M1 = CNT_W'(EW_MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] EW_MAX_M1 = CNT_W'(EW_MAX_GREEN - 1);
    localparam logic [CNT_W-1:0] YEL_M1    = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] AR_M1     = CNT_W'(ALLRED_T - 1);

    phase_e           r_state;
    phase_e           w_next;
    lamps_t           r_lamps;
    logic             r_ns_call;
    logic             r_ew_call;
    logic [CNT_W-1:0] w_timer;
    logic             w_phase_chg;
    logic             w_pre_ns;
    logic             w_pre_ew;
    logic             w_ns_gap;
    logic             w_ns_max;
    logic             w_ew_gap;
    logic             w_ew_max;
    logic             w_enter_ns;
    logic             w_enter_ew;

    assign w_pre_ns = i_preempt & ~i_preempt_dir;
    assign w_pre_ew = i_preempt &  i_preempt_dir;

    // Gap-out needs MIN served and an idle own approach; max-out ignores own demand.
    assign w_ns_gap = (w_timer >= NS_MIN_M1) & ~i_ns_detect;
    assign w_ns_max = (w_timer >= NS_MAX_M1);
    assign w_ew_gap = (w_timer >= EW_MIN_M1) & ~i_ew_detect;
    assign w_ew_max = (w_timer >= EW_MAX_M1);

    phase_timer #(
        .CNT_W (CNT_W)
    ) u_phase_timer (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (w_phase_chg),
        .i_tick  (i_tick),
        .o_cnt   (w_timer)
    );

    // Next-phase decision; phases only move on a tick, yellow and all-red always run full length.
    always_comb begin
        w_next = r_state;
        if (i_tick) begin
            case (r_state)
                NS_GRN: begin
                    if (w_pre_ew || (!w_pre_ns && r_ew_call && (w_ns_gap || w_ns_max)))
                        w_next = NS_YEL;
                end
                NS_YEL: begin
                    if (w_timer >= YEL_M1) w_next = AR_TO_EW;
                end
                AR_TO_EW: begin
                    if (w_timer >= AR_M1) w_next = w_pre_ns ? NS_GRN : EW_GRN;
                end
                EW_GRN: begin
                    if (w_pre_ns || (!w_pre_ew && r_ns_call && (w_ew_gap || w_ew_max)))
                        w_next = EW_YEL;
                end
                EW_YEL: begin
                    if (w_timer >= YEL_M1) w_next = AR_TO_NS;
                end
                AR_TO_NS: begin
                    if (w_timer >= AR_M1) w_next = w_pre_ew ? EW_GRN : NS_GRN;
                end
                default: w_next = NS_GRN;
            endcase
        end
    end

    assign w_phase_chg = (w_next != r_state);
    assign w_enter_ns  = (w_next == NS_GRN) && (r_state != NS_GRN);
    assign w_enter_ew  = (w_next == EW_GRN) && (r_state != EW_GRN);

    // Phase register, call latches (clear beats set) and lamp registers decoded from the next phase.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= NS_GRN;
            r_ns_call <= 1'b0;
            r_ew_call <= 1'b0;
            r_lamps   <= lamp_decode(NS_GRN);
        end else begin
            r_state   <= w_next;
            r_lamps   <= lamp_decode(w_next);
            r_ns_call <= w_enter_ns ? 1'b0
                                    : (r_ns_call | (i_ns_detect & (r_state != NS_GRN)));
            r_ew_call <= w_enter_ew ? 1'b0
                                    : (r_ew_call | (i_ew_detect & (r_state != EW_GRN)));
        end
    end

    assign o_ns_red    = r_lamps.ns_red;
    assign o_ns_yellow = r_lamps.ns_yellow;
    assign o_ns_green  = r_lamps.ns_green;
    assign o_ew_red    = r_lamps.ew_red;
    assign o_ew_yellow = r_lamps.ew_yellow;
    assign o_ew_green  = r_lamps.ew_green;
    assign o_state     = r_state;
    assign o_timer     = w_timer;

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Scoreboard bench: stimulus pushes model expectations, a monitor pops and compares each cycle.
// Latency: one expectation per clock edge after reset release.
// Backpressure: none.
module tb_traffic_phase_sequencer;

    localparam int TMAX = 31;
    localparam int YEL  = 3;
    localparam int AR   = 1;
    int MINS [2] = '{8, 4};
    int MAXS [2] = '{31, 15};

    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       i_tick = 1'b0;
    logic       i_ns_detect = 1'b0;
    logic       i_ew_detect = 1'b0;
    logic       i_preempt = 1'b0;
    logic       i_preempt_dir = 1'b0;
    logic       o_ns_red, o_ns_yellow, o_ns_green;
    logic       o_ew_red, o_ew_yellow, o_ew_green;
    logic [2:0] o_state;
    logic [4:0] o_timer;

    traffic_phase_sequencer dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_tick        (i_tick),
        .i_ns_detect   (i_ns_detect),
        .i_ew_detect   (i_ew_detect),
        .i_preempt     (i_preempt),
        .i_preempt_dir (i_preempt_dir),
        .o_ns_red      (o_ns_red),
        .o_ns_yellow   (o_ns_yellow),
        .o_ns_green    (o_ns_green),
        .o_ew_red      (o_ew_red),
        .o_ew_yellow   (o_ew_yellow),
        .o_ew_green    (o_ew_green),
        .o_state       (o_state),
        .o_timer       (o_timer)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int         st;
        int         tm;
        logic [5:0] lamps;
    } exp_t;

    exp_t sbq[$];
    int   n_vec = 0;
    int   n_err = 0;
    bit   started = 1'b0;

    // Reference model: green direction (0=NS,1=EW), stage (0 green, 1 yellow, 2 all-red), elapsed ticks.
    int m_dir, m_stage, m_el;
    bit m_call [2];

    function automatic void model_reset();
        m_dir = 0; m_stage = 0; m_el = 0;
        m_call[0] = 1'b0; m_call[1] = 1'b0;
    endfunction

    function automatic bit done(int t);
        return m_el >= t - 1;
    endfunction

    function automatic void model_step(bit tick, bit det_ns, bit det_ew, bit pre, bit pdir);
        bit det [2];
        int nd, ns, oth;
        det[0] = det_ns; det[1] = det_ew;
        nd = m_dir; ns = m_stage; oth = 1 - m_dir;
        if (tick) begin
            if (m_stage == 0) begin
                if ((pre && int'(pdir) == oth) ||
                    (!(pre && int'(pdir) == m_dir) && m_call[oth] &&
                     ((done(MINS[m_dir]) && !det[m_dir]) || done(MAXS[m_dir]))))
                    ns = 1;
            end else if (m_stage == 1) begin
                if (done(YEL)) ns = 2;
            end else begin
                if (done(AR)) begin
                    ns = 0;
                    nd = pre ? int'(pdir) : oth;
                end
            end
        end
        for (int x = 0; x < 2; x++)
            if (det[x] && !(m_dir == x && m_stage == 0)) m_call[x] = 1'b1;
        if (ns == 0 && (m_stage != 0 || nd != m_dir)) m_call[nd] = 1'b0;
        if (ns != m_stage || nd != m_dir) m_el = 0;
        else if (tick && m_el < TMAX) m_el = m_el + 1;
        m_dir = nd; m_stage = ns;
    endfunction

    function automatic logic [2:0] lamp_of(int x);
        if (x == m_dir && m_stage == 0) return 3'b001;
        if (x == m_dir && m_stage == 1) return 3'b010;
        return 3'b100;
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        e.st    = 3 * m_dir + m_stage;
        e.tm    = m_el;
        e.lamps = {lamp_of(0), lamp_of(1)};
        return e;
    endfunction

    function automatic logic [5:0] dut_lamps();
        return {o_ns_red, o_ns_yellow, o_ns_green, o_ew_red, o_ew_yellow, o_ew_green};
    endfunction

    function automatic int excl_ok();
        logic [5:0] l;
        l = dut_lamps();
        return int'($onehot(l[5:3]) && $onehot(l[2:0]) && !((l[4] | l[3]) && (l[1] | l[0])));
    endfunction

    task automatic chk(string nm, int act, int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_all(string nm, exp_t e);
        chk({nm, "_state"}, int'(o_state), e.st);
        chk({nm, "_timer"}, int'(o_timer), e.tm);
        chk({nm, "_lamps"}, int'(dut_lamps()), int'(e.lamps));
    endtask

    // Monitor: one expectation per clock edge, sampled 1 time unit after it.
    initial begin
        exp_t e;
        wait (started);
        forever begin
            @(posedge i_clk);
            #1;
            chk("lamp_excl", excl_ok(), 1);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk_all("mon", e);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Called at a falling edge; drives one cycle and returns at the next falling edge.
    task automatic cyc(bit t, bit nsd, bit ewd, bit pre, bit pdir);
        i_tick = t; i_ns_detect = nsd; i_ew_detect = ewd;
        i_preempt = pre; i_preempt_dir = pdir;
        model_step(t, nsd, ewd, pre, pdir);
        sbq.push_back(model_out());
        @(negedge i_clk);
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0;
        i_tick = 1'b0; i_ns_detect = 1'b0; i_ew_detect = 1'b0;
        i_preempt = 1'b0; i_preempt_dir = 1'b0;
        model_reset();
        #1;
        chk_all("reset", model_out());
        chk("reset_ns_green", int'(o_ns_green), 1);
        chk("reset_ew_red", int'(o_ew_red), 1);
        chk("reset_timer", int'(o_timer), 0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
    endtask

    initial begin
        bit r_pre, r_pdir;
        int n;
        @(negedge i_clk);
        do_reset();
        started = 1'b1;

        // Idle intersection: NS green rests, timer saturates.
        repeat (100) cyc(1, 0, 0, 0, 0);
        chk("idle_state", int'(o_state), 0);
        chk("idle_sat", int'(o_timer), 31);
        chk("idle_nsg", int'(o_ns_green), 1);
        chk("idle_ewr", int'(o_ew_red), 1);

        // EW call at tick 2 gaps NS out at MIN.
        do_reset();
        for (int k = 0; k < 12; k++) begin
            cyc(1, 0, k == 2, 0, 0);
            if (k == 6)  chk("gap_still_grn", int'(o_state), 0);
            if (k == 7)  chk("gap_ns_yel", int'(o_state), 1);
            if (k == 10) chk("gap_ar_to_ew", int'(o_state), 2);
            if (k == 11) chk("gap_ew_grn", int'(o_state), 3);
        end
        repeat (20) cyc(1, 0, 0, 0, 0);
        chk("ew_rest", int'(o_state), 3);

        // NS demand held: max-out on the 31st tick.
        do_reset();
        for (int k = 0; k < 31; k++) begin
            cyc(1, 1, k == 0, 0, 0);
            if (k == 29) chk("max_still_grn", int'(o_state), 0);
            if (k == 30) chk("max_ns_yel", int'(o_state), 1);
        end

        // Preempt to EW at tick 1; EW then held past MAX.
        do_reset();
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 1, 1);
        chk("pre_ns_yel", int'(o_state), 1);
        repeat (2) cyc(1, 0, 0, 1, 1);
        chk("pre_yel_full", int'(o_state), 1);
        cyc(1, 0, 0, 1, 1);
        chk("pre_ar", int'(o_state), 2);
        cyc(1, 0, 0, 1, 1);
        chk("pre_ew_grn", int'(o_state), 3);
        cyc(1, 1, 0, 1, 1);
        repeat (30) cyc(1, 0, 0, 1, 1);
        chk("pre_hold", int'(o_state), 3);
        chk("pre_hold_timer", int'(o_timer), 31);
        cyc(1, 0, 0, 0, 0);
        chk("pre_drop_yel", int'(o_state), 4);
        cyc(1, 0, 0, 0, 0);
        chk("mid_yel", int'(o_state), 4);
        do_reset();

        // Preempt to NS raised during all-red towards EW.
        cyc(1, 0, 1, 0, 0);
        n = 0;
        while (!(m_dir == 0 && m_stage == 2) && n < 50) begin
            cyc(1, 0, 0, 0, 0);
            n++;
        end
        chk("ar_reached", int'(o_state), 2);
        cyc(1, 0, 0, 1, 0);
        chk("ar_pre_ns", int'(o_state), 0);

        // Randomized traffic with sticky preempt and occasional resets.
        r_pre = 1'b0; r_pdir = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 39) == 0) r_pre = ~r_pre;
            if ($urandom_range(0, 39) == 0) r_pdir = ~r_pdir;
            if ($urandom_range(0, 249) == 0) do_reset();
            else cyc($urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0,
                     $urandom_range(0, 7) == 0, r_pre, r_pdir);
        end

        n = 0;
        while (sbq.size() > 0 && n < 10) begin
            @(negedge i_clk);
            n++;
        end
        chk("queue_drained", sbq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
